// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - point counting, goal/win pulses and ball freeze for one match
module score_keeper #(
    parameter int WIN_SCORE  = 5,
    parameter int SCORE_W    = 4,
    parameter int HOLD_TICKS = 32
) (
    input  logic               BALL_CLOCK,
    input  logic               RESET,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               goal_player_1,
    output logic               goal_player_2,
    output logic               win_player_1,
    output logic               win_player_2,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               ball_enable,
    output logic               serve_to_player_1
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [SCORE_W-1:0] LAST_POINT = SCORE_W'(WIN_SCORE - 1);
    localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HOLD,
        OVER
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_count;

    always_ff @(posedge BALL_CLOCK or posedge RESET) begin
        if (RESET) begin
            state             <= IDLE;
            score_1           <= '0;
            score_2           <= '0;
            goal_player_1     <= 1'b0;
            goal_player_2     <= 1'b0;
            win_player_1      <= 1'b0;
            win_player_2      <= 1'b0;
            ball_enable       <= 1'b0;
            serve_to_player_1 <= 1'b0;
            hold_count        <= '0;
        end else begin
            // pulses are single-cycle: only the scoring branch below re-raises one
            goal_player_1 <= 1'b0;
            goal_player_2 <= 1'b0;
            win_player_1  <= 1'b0;
            win_player_2  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PLAY;
                        score_1     <= '0;
                        score_2     <= '0;
                        ball_enable <= 1'b1;
                    end
                end

                PLAY: begin
                    if (miss_right && !miss_left) begin
                        score_1 <= score_1 + 1'b1;
                        if (score_1 == LAST_POINT) begin
                            win_player_1 <= 1'b1;
                            state        <= OVER;
                        end else begin
                            goal_player_1     <= 1'b1;
                            serve_to_player_1 <= 1'b0;
                            hold_count        <= HOLD_LOAD;
                            state             <= HOLD;
                        end
                        ball_enable <= 1'b0;
                    end else if (miss_left && !miss_right) begin
                        score_2 <= score_2 + 1'b1;
                        if (score_2 == LAST_POINT) begin
                            win_player_2 <= 1'b1;
                            state        <= OVER;
                        end else begin
                            goal_player_2     <= 1'b1;
                            serve_to_player_1 <= 1'b1;
                            hold_count        <= HOLD_LOAD;
                            state             <= HOLD;
                        end
                        ball_enable <= 1'b0;
                    end
                end

                HOLD: begin
                    if (hold_count == '0) begin
                        state       <= PLAY;
                        ball_enable <= 1'b1;
                    end else begin
                        hold_count <= hold_count - 1'b1;
                    end
                end

                OVER: begin
                    if (start) begin
                        // next serve goes toward whoever did not reach the winning score
                        serve_to_player_1 <= (score_2 == WIN_VALUE);
                        score_1           <= '0;
                        score_2           <= '0;
                        ball_enable       <= 1'b1;
                        state             <= PLAY;
                    end
                end

                default: begin
                    state       <= IDLE;
                    ball_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper
module tb_score_keeper;

    logic       BALL_CLOCK;
    logic       RESET;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       goal_player_1;
    logic       goal_player_2;
    logic       win_player_1;
    logic       win_player_2;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       ball_enable;
    logic       serve_to_player_1;

    int errors = 0;
    int checks = 0;

    score_keeper #(
        .WIN_SCORE (5),
        .SCORE_W   (4),
        .HOLD_TICKS(32)
    ) dut (
        .BALL_CLOCK       (BALL_CLOCK),
        .RESET            (RESET),
        .start            (start),
        .miss_left        (miss_left),
        .miss_right       (miss_right),
        .goal_player_1    (goal_player_1),
        .goal_player_2    (goal_player_2),
        .win_player_1     (win_player_1),
        .win_player_2     (win_player_2),
        .score_1          (score_1),
        .score_2          (score_2),
        .ball_enable      (ball_enable),
        .serve_to_player_1(serve_to_player_1)
    );

    initial BALL_CLOCK = 1'b0;
    always #5 BALL_CLOCK = ~BALL_CLOCK;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge BALL_CLOCK);
        @(negedge BALL_CLOCK);
    endtask

    task automatic point(input logic right);
        miss_right = right;
        miss_left  = ~right;
        cycle();
        miss_right = 1'b0;
        miss_left  = 1'b0;
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (!ball_enable && n < 100) begin
            cycle();
            n++;
        end
        if (!ball_enable) check("hold_timeout", 0, 1);
    endtask

    function automatic int pulses();
        return int'(goal_player_1) + int'(goal_player_2) + int'(win_player_1) + int'(win_player_2);
    endfunction

    initial begin
        int frozen;
        RESET = 1'b1; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        cycle(); cycle();
        check("rst_score_1", score_1, 0);
        check("rst_score_2", score_2, 0);
        check("rst_pulses", pulses(), 0);
        check("rst_ball_enable", ball_enable, 0);
        check("rst_serve", serve_to_player_1, 0);
        RESET = 1'b0;
        repeat (5) cycle();
        check("idle_ball_enable", ball_enable, 0);
        check("idle_pulses", pulses(), 0);

        start = 1'b1; cycle(); start = 1'b0;
        check("start_ball_enable", ball_enable, 1);
        check("start_score_1", score_1, 0);

        // first goal, with misses and start thrown in during the freeze
        point(1'b1);
        check("goal1_pulse", goal_player_1, 1);
        check("goal1_others", pulses(), 1);
        check("goal1_score_1", score_1, 1);
        check("goal1_ball_enable", ball_enable, 0);
        check("goal1_serve", serve_to_player_1, 0);
        frozen = 1;
        for (int i = 0; i < 100 && !ball_enable; i++) begin
            miss_left = (i % 5 == 2);
            start     = (i % 7 == 3);
            cycle();
            if (i == 0) check("goal1_pulse_width", goal_player_1, 0);
            if (!ball_enable) frozen++;
        end
        miss_left = 1'b0; start = 1'b0;
        check("hold_length", frozen, 32);
        check("hold_score_2", score_2, 0);
        check("hold_score_1", score_1, 1);

        miss_left = 1'b1; miss_right = 1'b1; cycle();
        miss_left = 1'b0; miss_right = 1'b0;
        check("both_pulses", pulses(), 0);
        check("both_score_1", score_1, 1);
        check("both_score_2", score_2, 0);
        check("both_ball_enable", ball_enable, 1);

        repeat (3) begin point(1'b1); wait_play(); end
        check("four_score_1", score_1, 4);
        point(1'b0);
        check("goal2_pulse", goal_player_2, 1);
        check("goal2_score_2", score_2, 1);
        check("goal2_serve", serve_to_player_1, 1);
        wait_play();

        point(1'b1);
        check("win1_pulse", win_player_1, 1);
        check("win1_goal", goal_player_1, 0);
        check("win1_score_1", score_1, 5);
        check("win1_ball_enable", ball_enable, 0);
        check("win1_serve_kept", serve_to_player_1, 1);
        cycle();
        check("win1_pulse_width", win_player_1, 0);
        point(1'b0); point(1'b1); repeat (3) cycle();
        check("over_score_1", score_1, 5);
        check("over_score_2", score_2, 1);
        check("over_pulses", pulses(), 0);
        check("over_ball_enable", ball_enable, 0);

        start = 1'b1; cycle(); start = 1'b0;
        check("restart_score_1", score_1, 0);
        check("restart_score_2", score_2, 0);
        check("restart_ball_enable", ball_enable, 1);
        check("restart_serve", serve_to_player_1, 0);

        repeat (3) begin point(1'b1); wait_play(); end
        point(1'b0); wait_play();
        point(1'b0);
        repeat (4) cycle();
        check("mid_hold_score_1", score_1, 3);
        check("mid_hold_score_2", score_2, 2);
        #2 RESET = 1'b1;
        #1;
        check("async_score_1", score_1, 0);
        check("async_score_2", score_2, 0);
        check("async_ball_enable", ball_enable, 0);
        check("async_serve", serve_to_player_1, 0);
        @(negedge BALL_CLOCK);
        RESET = 1'b0;
        repeat (40) cycle();
        check("post_rst_idle", ball_enable, 0);
        start = 1'b1; cycle(); start = 1'b0;
        check("post_rst_play", ball_enable, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
